// File: rtl/shot_clock_ctrl_pkg.sv
// rtl/shot_clock_ctrl_pkg.sv - shared state encoding and BCD helper for the shot clock
package shot_clock_ctrl_pkg;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_RUN     = 2'd1;
   localparam logic [1:0] ST_PAUSE   = 2'd2;
   localparam logic [1:0] ST_EXPIRED = 2'd3;

   // Elaboration-time split of a decimal 0..99 value into {tens, ones} BCD digits.
   function automatic logic [7:0] bcd_split(input int v);
      logic [3:0] t;
      logic [3:0] o;
      t = 4'(v / 10);
      o = 4'(v % 10);
      return {t, o};
   endfunction

endpackage

// File: rtl/Num.sv
// rtl/Num.sv - BCD digit to 7-segment decoder, {dp,g,f,e,d,c,b,a} active-high
module Num (
   input  logic [3:0] num,
   output logic [7:0] seg
);

   always_comb begin
      seg = 8'h00;
      case (num)
         4'd0: seg = 8'h3F;
         4'd1: seg = 8'h06;
         4'd2: seg = 8'h5B;
         4'd3: seg = 8'h4F;
         4'd4: seg = 8'h66;
         4'd5: seg = 8'h6D;
         4'd6: seg = 8'h7D;
         4'd7: seg = 8'h07;
         4'd8: seg = 8'h7F;
         4'd9: seg = 8'h6F;
         default: seg = 8'h00;
      endcase
   end

endmodule

// File: rtl/shot_clock_ctrl_tick_prescaler.sv
// rtl/shot_clock_ctrl_tick_prescaler.sv - divides clk down to one count tick per CLK_DIV cycles
module shot_clock_ctrl_tick_prescaler #(
   parameter int CLK_DIV = 50000000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

   logic [W-1:0] cnt;

   assign tick = en && (cnt == LAST);

   // Holding while disabled keeps the fractional second across a pause.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= tick ? '0 : cnt + W'(1);
      end
   end

endmodule

// File: rtl/shot_clock_ctrl.sv
// rtl/shot_clock_ctrl.sv - button-driven two-digit BCD shot clock with expiry buzzer
module shot_clock_ctrl
   import shot_clock_ctrl_pkg::*;
#(
   parameter int CLK_DIV    = 50000000,
   parameter int RELOAD_A   = 24,
   parameter int RELOAD_B   = 14,
   parameter int BUZZ_TICKS = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       pause,
   input  logic       reload_a,
   input  logic       reload_b,
   output logic [3:0] ten,
   output logic [3:0] one,
   output logic       running,
   output logic       buzz,
   output logic [7:0] segO1,
   output logic [7:0] segO2
);

   localparam logic [7:0] LOAD_A = bcd_split(RELOAD_A);
   localparam logic [7:0] LOAD_B = bcd_split(RELOAD_B);
   localparam int BW = (BUZZ_TICKS > 0) ? $clog2(BUZZ_TICKS + 1) : 1;
   localparam logic [BW-1:0] BUZZ_LAST = BW'(BUZZ_TICKS - 1);

   logic [1:0]    state;
   logic [BW-1:0] buzz_cnt;
   logic          tick;
   logic          pre_en;
   logic          reload;

   assign reload  = reload_a | reload_b;
   // A pause in RUN also freezes the prescaler on that very cycle, so a coincident tick is dropped.
   assign pre_en  = ((state == ST_RUN) && !pause) || (state == ST_EXPIRED);
   assign running = (state == ST_RUN);
   assign buzz    = (state == ST_EXPIRED);

   shot_clock_ctrl_tick_prescaler #(
      .CLK_DIV (CLK_DIV)
   ) u_tick_prescaler (
      .clk  (clk),
      .rst  (rst),
      .en   (pre_en),
      .clr  (reload),
      .tick (tick)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= ST_IDLE;
         ten      <= LOAD_A[7:4];
         one      <= LOAD_A[3:0];
         buzz_cnt <= '0;
      end else if (reload_a) begin
         state    <= ST_IDLE;
         ten      <= LOAD_A[7:4];
         one      <= LOAD_A[3:0];
         buzz_cnt <= '0;
      end else if (reload_b) begin
         state    <= ST_IDLE;
         ten      <= LOAD_B[7:4];
         one      <= LOAD_B[3:0];
         buzz_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start && ({ten, one} != 8'h00)) begin
                  state <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (pause) begin
                  state <= ST_PAUSE;
               end else if (tick) begin
                  // 01 and the never-expected 00 both land on 00, so the count cannot wrap.
                  if ({ten, one} <= 8'h01) begin
                     ten      <= 4'd0;
                     one      <= 4'd0;
                     state    <= ST_EXPIRED;
                     buzz_cnt <= '0;
                  end else if (one != 4'd0) begin
                     one <= one - 4'd1;
                  end else begin
                     one <= 4'd9;
                     ten <= ten - 4'd1;
                  end
               end
            end
            ST_PAUSE: begin
               if (start) begin
                  state <= ST_RUN;
               end
            end
            ST_EXPIRED: begin
               if (tick) begin
                  if (buzz_cnt == BUZZ_LAST) begin
                     state    <= ST_IDLE;
                     buzz_cnt <= '0;
                  end else begin
                     buzz_cnt <= buzz_cnt + BW'(1);
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   Num u_num_ten (
      .num (ten),
      .seg (segO1)
   );

   Num u_num_one (
      .num (one),
      .seg (segO2)
   );

endmodule

// File: tb/tb_shot_clock_ctrl.sv
// tb/tb_shot_clock_ctrl.sv - randomized and directed bench for shot_clock_ctrl against a seconds-level model
module tb_shot_clock_ctrl;

   localparam int CLK_DIV    = 4;
   localparam int RELOAD_A   = 24;
   localparam int RELOAD_B   = 14;
   localparam int BUZZ_TICKS = 3;

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_PAUSE = 2;
   localparam int M_EXP   = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       pause = 1'b0;
   logic       reload_a = 1'b0;
   logic       reload_b = 1'b0;
   logic [3:0] ten;
   logic [3:0] one;
   logic       running;
   logic       buzz;
   logic [7:0] segO1;
   logic [7:0] segO2;

   int n_checks = 0;
   int n_fail   = 0;

   int m_secs  = RELOAD_A;
   int m_mode  = M_IDLE;
   int m_frac  = 0;
   int m_left  = 0;

   always #5 clk = ~clk;

   shot_clock_ctrl #(
      .CLK_DIV    (CLK_DIV),
      .RELOAD_A   (RELOAD_A),
      .RELOAD_B   (RELOAD_B),
      .BUZZ_TICKS (BUZZ_TICKS)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .pause    (pause),
      .reload_a (reload_a),
      .reload_b (reload_b),
      .ten      (ten),
      .one      (one),
      .running  (running),
      .buzz     (buzz),
      .segO1    (segO1),
      .segO2    (segO2)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [7:0] seg_of(input int d);
      logic [7:0] tbl [10];
      tbl = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
      return tbl[d];
   endfunction

   // Model tracks whole seconds left plus the elapsed fraction of the current second.
   task automatic model_step(input logic r, input logic s, input logic p, input logic a, input logic b);
      if (!r) begin
         m_secs = RELOAD_A; m_mode = M_IDLE; m_frac = 0; m_left = 0;
      end else if (a) begin
         m_secs = RELOAD_A; m_mode = M_IDLE; m_frac = 0; m_left = 0;
      end else if (b) begin
         m_secs = RELOAD_B; m_mode = M_IDLE; m_frac = 0; m_left = 0;
      end else if (m_mode == M_IDLE) begin
         if (s && m_secs > 0) m_mode = M_RUN;
      end else if (m_mode == M_RUN) begin
         if (p) begin
            m_mode = M_PAUSE;
         end else begin
            m_frac++;
            if (m_frac == CLK_DIV) begin
               m_frac = 0;
               m_secs--;
               if (m_secs == 0) begin
                  m_mode = M_EXP;
                  m_left = BUZZ_TICKS;
               end
            end
         end
      end else if (m_mode == M_PAUSE) begin
         if (s) m_mode = M_RUN;
      end else begin
         m_frac++;
         if (m_frac == CLK_DIV) begin
            m_frac = 0;
            m_left--;
            if (m_left == 0) m_mode = M_IDLE;
         end
      end
   endtask

   task automatic cyc(input logic r, input logic s, input logic p, input logic a, input logic b);
      rst = r; start = s; pause = p; reload_a = a; reload_b = b;
      @(posedge clk);
      model_step(r, s, p, a, b);
      #1;
      rst = 1'b1; start = 1'b0; pause = 1'b0; reload_a = 1'b0; reload_b = 1'b0;
      check("ten", ten, m_secs / 10);
      check("one", one, m_secs % 10);
      check("running", running, m_mode == M_RUN);
      check("buzz", buzz, m_mode == M_EXP);
      check("seg_ten", segO1, seg_of(m_secs / 10));
      check("seg_one", segO2, seg_of(m_secs % 10));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0);
   endtask

   task automatic expect_count(input string tag, input int t, input int o, input logic run, input logic bz);
      check({tag, "_ten"}, ten, t);
      check({tag, "_one"}, one, o);
      check({tag, "_running"}, running, run);
      check({tag, "_buzz"}, buzz, bz);
   endtask

   initial begin
      int bc;
      int guard;

      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      expect_count("reset", 2, 4, 0, 0);
      idle(20);
      expect_count("idle20", 2, 4, 0, 0);

      cyc(1, 1, 0, 0, 0);
      check("start_running", running, 1);
      idle(4);
      expect_count("first_tick", 2, 3, 1, 0);
      idle(16);
      expect_count("borrow", 1, 9, 1, 0);

      cyc(1, 0, 0, 1, 0);
      cyc(1, 1, 0, 0, 0);
      idle(6);
      cyc(1, 0, 1, 0, 0);
      idle(12);
      expect_count("paused", 2, 3, 0, 0);
      cyc(1, 1, 0, 0, 0);
      idle(1);
      expect_count("resume1", 2, 3, 1, 0);
      idle(1);
      expect_count("resume2", 2, 2, 1, 0);

      cyc(1, 0, 0, 0, 1);
      expect_count("reload_b", 1, 4, 0, 0);
      cyc(1, 1, 0, 0, 0);
      idle(55);
      expect_count("pre_expiry", 0, 1, 1, 0);
      idle(1);
      expect_count("expired", 0, 0, 0, 1);
      bc = 1;
      guard = 0;
      while (buzz && guard < 40) begin
         idle(1);
         if (buzz) bc++;
         guard++;
      end
      check("buzz_cycles", bc, BUZZ_TICKS * CLK_DIV);
      expect_count("after_buzz", 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 0);
      expect_count("start_at_zero", 0, 0, 0, 0);

      cyc(1, 1, 0, 0, 1);
      cyc(1, 1, 0, 0, 0);
      idle(5);
      cyc(1, 1, 0, 1, 0);
      expect_count("reload_a_start", 2, 4, 0, 0);

      cyc(1, 1, 0, 0, 0);
      idle(3);
      cyc(1, 0, 1, 0, 0);
      expect_count("pause_on_tick", 2, 4, 0, 0);
      idle(3);
      expect_count("pause_on_tick_hold", 2, 4, 0, 0);

      cyc(1, 0, 0, 0, 1);
      cyc(1, 1, 0, 0, 0);
      idle(58);
      check("exp_before_reload", buzz, 1);
      cyc(1, 0, 0, 0, 1);
      expect_count("reload_b_in_exp", 1, 4, 0, 0);

      cyc(1, 0, 0, 1, 0);
      cyc(1, 1, 0, 0, 0);
      idle(68);
      expect_count("count07", 0, 7, 1, 0);
      cyc(0, 0, 0, 0, 0);
      expect_count("rst_in_run", 2, 4, 0, 0);

      cyc(1, 0, 0, 0, 1);
      cyc(1, 1, 0, 0, 0);
      idle(59);
      check("exp_before_rst", buzz, 1);
      cyc(0, 0, 0, 0, 0);
      expect_count("rst_in_exp", 2, 4, 0, 0);

      for (int i = 0; i < 4000; i++) begin
         cyc(($urandom_range(0, 499) != 0),
             ($urandom_range(0, 11) == 0),
             ($urandom_range(0, 29) == 0),
             ($urandom_range(0, 149) == 0),
             ($urandom_range(0, 119) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/shot_clock_ctrl.md
Name: shot_clock_ctrl

Overview:
Controller for the two-digit 24 s countdown display. It owns the BCD count, derives the 1 s tick from the board clock, and sequences start/pause/reload/expiry. It drives the buzzer and feeds the existing 7-segment digit decoder (Num) for both digits. It replaces the free-running reset-only countdown with a button-driven shot clock.

Parameters:
CLK_DIV, 50000000, clk cycles per count tick (≥2; benches use 4)
RELOAD_A, 24, full reload value, decimal 1..99
RELOAD_B, 14, short reload value, decimal 1..99
BUZZ_TICKS, 3, count ticks the buzzer stays on after expiry (≥1)

Ports:
clk  in  1  system clock, single clock domain
rst  in  1  reset, synchronous, active-low
start  in  1  one-cycle pulse (debounced upstream): begin/resume counting
pause  in  1  one-cycle pulse: freeze count
reload_a  in  1  one-cycle pulse: load RELOAD_A and stop
reload_b  in  1  one-cycle pulse: load RELOAD_B and stop
ten  out  4  BCD tens digit
one  out  4  BCD ones digit
running  out  1  high in RUN
buzz  out  1  high in EXPIRED
segO1  out  8  segments for ten (via Num)
segO2  out  8  segments for one (via Num)

Behaviour:
- All state registers update on posedge clk. rst==0 sampled at an edge -> ten/one = RELOAD_A digits (2,4), state IDLE, prescaler=0, buzz_cnt=0, running=0, buzz=0. Reset mid-count or mid-buzz is identical to reset from idle.
- States: IDLE (stopped, count valid), RUN, PAUSE, EXPIRED.
- Per-cycle command priority: reload_a > reload_b > pause > start. Lower-priority pulses in the same cycle are ignored.
- reload_a or reload_b in any state -> load value, prescaler=0, buzz_cnt=0, next state IDLE. Value visible on ten/one the cycle after the pulse.
- IDLE: start with count!=00 -> RUN. start with count==00 is ignored. pause is ignored.
- RUN: the prescaler counts 0..CLK_DIV-1. tick = (prescaler==CLK_DIV-1), and the prescaler wraps to 0 on that cycle. The first tick is CLK_DIV cycles after the start edge.
- RUN on tick: if one!=0 then one-1, else one=9 and ten-1.
  - If the pre-decrement count is 01, the result is 00 and the next state is EXPIRED (prescaler continues).
  - The count never wraps below 00.
- RUN + pause -> PAUSE. The prescaler holds its value, so the fractional second is preserved. If pause and tick coincide, pause wins and no decrement occurs.
- PAUSE: start -> RUN, resuming the prescaler from its held value. Count is frozen.
- EXPIRED: buzz=1. The prescaler keeps running and buzz_cnt increments on each tick. On the tick where buzz_cnt==BUZZ_TICKS-1, the next state is IDLE, buzz drops, and count remains 00. start and pause are ignored; reload exits immediately.
- running = (state==RUN). buzz = (state==EXPIRED). Both are registered/state-decoded with no extra latency.
- Width rules: prescaler width = $clog2(CLK_DIV). buzz_cnt width = $clog2(BUZZ_TICKS+1). BCD digits are always 0..9; RELOAD values are split into digits as /10 and %10 at elaboration.

Decomposition:
- Shared package: state encoding (IDLE=0, RUN=1, PAUSE=2, EXPIRED=3) and a BCD-split constant function for the reload values.
- One natural sub-module: tick_prescaler (clk, rst, en, clr -> tick). The enable is (state==RUN || state==EXPIRED); the clear is reload.
- Digit decoding reuses the existing Num instance twice; it is not redefined here.

Test Plan:
- Reset (CLK_DIV=4): hold rst=0 for 2 cycles -> ten=2, one=4, running=0, buzz=0; no change for 20 idle cycles.
- Start at 24 -> running=1. After 4 cycles count is 23; after 4*5 cycles count is 19 (borrow across the tens digit).
- Pause after 6 cycles of RUN (count 23, prescaler=2) -> frozen 10+ cycles. Start -> next decrement to 22 occurs exactly 2 cycles later.
- Count to expiry from reload_b (14) -> after 14 ticks count=00, buzz=1 for exactly 3*4=12 cycles, then IDLE with 00. A following start is ignored (running stays 0).
- Simultaneous pulses:
  - reload_a+start in RUN -> IDLE at 24.
  - pause coincident with a tick -> PAUSE, no decrement.
  - reload_b during EXPIRED -> buzz drops next cycle, count=14.
- Reset mid-operation: rst=0 during RUN at count 07 and again during EXPIRED -> 24, IDLE, buzz=0 on the following cycle.
